bus_timer: RTL and testbench

- Memory-mapped programmable countdown timer; the responder end of the CPU system bus in the P7 microsystem.
- The CPU writes and reads its three registers through the bridge.
- The timer raises an interrupt request that feeds the CPU's exception/interrupt logic.
- Modes: one-shot (mode 0) and auto-reload (mode 1).

---
 rtl/bus_timer.sv | 109 ++++++++++
 tb/tb_bus_timer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Three registers (CTRL, PRESET, COUNT) sit on a two-bit word address; irq is the flag masked by im.
module bus_timer #(
    parameter logic [31:0] PRESET_INIT  = 32'h0000_0000,
    parameter logic [1:0]  DEFAULT_MODE = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nx;
    logic        en, en_nx;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count, count_nx;
    logic        irq_flag, flag_nx;
    logic        wr_ctrl, wr_preset, reload;

    assign wr_ctrl   = we && (addr == 2'd0);
    assign wr_preset = we && (addr == 2'd1);
    assign reload    = (mode == 2'b01);
    assign irq       = irq_flag & im;

    always_comb begin
        state_nx = state;
        count_nx = count;
        en_nx    = en;
        flag_nx  = irq_flag;
        case (state)
            IDLE: if (en) state_nx = LOAD;
            LOAD: begin
                count_nx = preset;
                flag_nx  = 1'b0;
                state_nx = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (count == 32'd0) begin
                    state_nx = INT;
                end else if (count == 32'd1) begin
                    count_nx = 32'd0;
                    state_nx = INT;
                end else begin
                    count_nx = count - 32'd1;
                end
            end
            INT: begin
                flag_nx = 1'b1;
                if (reload) begin
                    state_nx = LOAD;
                end else begin
                    en_nx    = 1'b0;
                    state_nx = IDLE;
                end
            end
        endcase
        // A CTRL write overrides every FSM action in the same cycle, including the count update.
        if (wr_ctrl) begin
            state_nx = IDLE;
            count_nx = count;
            en_nx    = wdata[0];
            flag_nx  = 1'b0;
        end else if (wr_preset) begin
            flag_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            en       <= 1'b0;
            mode     <= DEFAULT_MODE;
            im       <= 1'b0;
            preset   <= PRESET_INIT;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_nx;
            en       <= en_nx;
            count    <= count_nx;
            irq_flag <= flag_nx;
            if (wr_ctrl) begin
                mode <= wdata[2:1];
                im   <= wdata[3];
            end
            if (wr_preset) preset <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata = {28'b0, im, mode, en};
            2'd1: rdata = preset;
            2'd2: rdata = count;
            2'd3: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer: reset, one-shot, auto-reload, boundaries, collisions.
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int unsigned tests = 0;
    int unsigned fails = 0;

    bus_timer #(.PRESET_INIT(32'h0000_0000), .DEFAULT_MODE(2'b00)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        reset = 1'b0; addr = 2'd0; we = 1'b0; wdata = '0;
        tick(3);
        chk_irq("rst_irq", 1'b0);
        chk_rd("rst_ctrl", 2'd0, 32'd0);
        chk_rd("rst_preset", 2'd1, 32'd0);
        chk_rd("rst_count", 2'd2, 32'd0);
        reset = 1'b1;
        tick(1);

        // One-shot, PRESET=5, im=1
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(2);
        chk_rd("os_count_e2", 2'd2, 32'd5);
        for (int i = 4; i >= 0; i--) begin
            tick(1);
            chk_rd("os_count", 2'd2, 32'(i));
            chk_irq("os_irq_low", 1'b0);
        end
        tick(1);
        chk_irq("os_irq_e8", 1'b1);
        chk_rd("os_ctrl_en_clr", 2'd0, 32'h8);
        tick(2);
        chk_irq("os_irq_hold", 1'b1);
        chk_rd("reserved_rd", 2'd3, 32'd0);
        wr(2'd0, 32'h0);
        chk_irq("os_irq_cleared", 1'b0);

        // Auto-reload, PRESET=3: irq every 5 cycles starting at edge 6
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 25; e++) begin
            tick(1);
            chk_irq("ar_irq", (e >= 6) && ((e - 6) % 5 == 0));
            if (e == 2 || (e >= 7 && (e - 7) % 5 == 0))
                chk_rd("ar_reload", 2'd2, 32'd3);
        end
        wr(2'd0, 32'h0);
        chk_irq("ar_stop", 1'b0);

        // Boundaries: PRESET=0 and PRESET=1 both fire after edge 4
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(3);
        chk_irq("p0_e3", 1'b0);
        tick(1);
        chk_irq("p0_e4", 1'b1);
        wr(2'd1, 32'd1);
        chk_irq("preset_wr_clr", 1'b0);
        wr(2'd0, 32'h9);
        tick(2);
        chk_rd("p1_count_e2", 2'd2, 32'd1);
        tick(1);
        chk_irq("p1_e3", 1'b0);
        tick(1);
        chk_irq("p1_e4", 1'b1);

        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h9);
        tick(2);
        for (int k = 0; k < 10; k++) begin
            chk_rd("max_dec", 2'd2, 32'hFFFF_FFFF - 32'(k));
            tick(1);
        end
        wr(2'd0, 32'h0);

        // Clear en mid-count at COUNT=7: count holds, no irq
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(5);
        chk_rd("en_clr_pre", 2'd2, 32'd7);
        wr(2'd0, 32'h8);
        tick(12);
        chk_rd("en_clr_hold", 2'd2, 32'd7);
        chk_irq("en_clr_irq", 1'b0);

        // PRESET write during CNT does not disturb the countdown
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);
        tick(3);
        wr(2'd1, 32'd20);
        chk_rd("pw_count_e4", 2'd2, 32'd4);
        chk_rd("pw_preset", 2'd1, 32'd20);
        tick(4);
        chk_irq("pw_e8", 1'b0);
        tick(1);
        chk_irq("pw_e9", 1'b1);
        wr(2'd0, 32'h0);

        // im=0 expiry keeps irq low
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        tick(6);
        chk_irq("mask_irq", 1'b0);
        chk_rd("mask_ctrl", 2'd0, 32'h0);

        // CTRL write exactly in the INT cycle (edge 5): flag never set
        wr(2'd0, 32'h9);
        tick(4);
        wr(2'd0, 32'h8);
        chk_irq("coll_e5", 1'b0);
        tick(3);
        chk_irq("coll_after", 1'b0);
        chk_rd("coll_ctrl", 2'd0, 32'h8);

        // PRESET write in the INT cycle: flag stays 0, new PRESET loads next time
        wr(2'd0, 32'h9);
        tick(4);
        wr(2'd1, 32'd7);
        chk_irq("pcoll_e5", 1'b0);
        tick(3);
        chk_irq("pcoll_after", 1'b0);
        wr(2'd0, 32'h9);
        tick(2);
        chk_rd("pcoll_newload", 2'd2, 32'd7);

        // Asynchronous reset mid-count
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(3);
        #2;
        reset = 1'b0;
        #1;
        chk_rd("arst_count", 2'd2, 32'd0);
        chk_rd("arst_ctrl", 2'd0, 32'd0);
        chk_rd("arst_preset", 2'd1, 32'd0);
        chk_irq("arst_irq", 1'b0);
        tick(3);
        reset = 1'b1;
        tick(10);
        chk_irq("arst_no_pending", 1'b0);
        chk_rd("arst_idle_count", 2'd2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
